// File: rtl/toomcook_issue_scheduler.sv
// toomcook_issue_scheduler
//   Issue and stall control for one STAGE-deep Toom-Cook multiplier pipeline
//   that is shared by N requesters. Each cycle a round-robin arbiter may admit
//   one operand set into the tail slot (STAGE-1). The scheduler keeps a valid
//   bit and a requester tag for every slot. It drives the per-slot datapath
//   register enables, which lets bubbles be squeezed out while the head is
//   stalled. Results leave slot 0 in admission order, tagged with the ID of
//   the requester that issued them.
//
// Optional feature (compile-time macro TOOMCOOK_SCHED_CREDIT_EN):
//   Each requester gets a credit counter of its outstanding entries. A
//   requester that already has MAX_OUT entries in flight is skipped by the
//   arbiter. When the macro is undefined, MAX_OUT has no effect.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  [N]       request r has operands ready
//   req_ready  [N]       one-hot grant (combinational)
//   dp_load    operands of the granted requester load into slot STAGE-1
//   dp_sel     [IDW]     operand mux select (0 when !dp_load)
//   stage_en   [STAGE]   bit i moves slot i+1 into slot i
//   out_valid  head slot 0 holds a valid result
//   out_ready  consumer accepts the head result
//   out_id     [IDW]     requester ID of the head result (0 when !out_valid)
//   occupancy  [CW]      number of valid slots
module toomcook_issue_scheduler #(
  parameter int N       = 4,
  parameter int STAGE   = 8,
  parameter int MAX_OUT = 3,
  localparam int IDW    = $clog2(N),
  localparam int CW     = $clog2(STAGE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  output logic             dp_load,
  output logic [IDW-1:0]   dp_sel,
  output logic [STAGE-1:0] stage_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDW-1:0]   out_id,
  output logic [CW-1:0]    occupancy
);

  logic [STAGE-1:0] valid_q, valid_d;
  logic [IDW-1:0]   tag_q [STAGE];
  logic [IDW-1:0]   tag_d [STAGE];
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N-1:0]     elig;
  logic             rel;

  assign out_valid = valid_q[0];
  assign out_id    = valid_q[0] ? tag_q[0] : '0;
  assign rel       = out_valid & out_ready;

  // A slot may advance when a bubble exists at or below it, or when the head
  // drains this cycle. Stopped slots are therefore always a contiguous valid
  // run that starts at the head.
  for (genvar gi = 0; gi < STAGE; gi++) begin : g_stage_en
    assign stage_en[gi] = ~(&valid_q[gi:0]) | rel;
  end

`ifdef TOOMCOOK_SCHED_CREDIT_EN
  localparam int CRW = $clog2(MAX_OUT + 1);

  for (genvar gi = 0; gi < N; gi++) begin : g_credit
    logic [CRW-1:0] credit_q, credit_d;
    logic           inc, dec;

    assign elig[gi] = req_valid[gi] && (credit_q < CRW'(MAX_OUT));
    assign inc      = req_ready[gi];
    assign dec      = rel && (out_id == IDW'(gi));

    // A grant and a release on the same cycle cancel each other. The guards
    // keep the counter inside 0..MAX_OUT.
    always_comb begin
      credit_d = credit_q;
      if (inc && !dec && (credit_q != CRW'(MAX_OUT))) begin
        credit_d = credit_q + CRW'(1);
      end else if (dec && !inc && (credit_q != '0)) begin
        credit_d = credit_q - CRW'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) credit_q <= '0;
      else     credit_q <= credit_d;
    end
  end
`else
  // MAX_OUT only matters when credit tracking is compiled in.
  logic unused_max_out;
  assign unused_max_out = (MAX_OUT != 0);
  assign elig = req_valid;
`endif

  // Round-robin arbiter. The scan starts one past the last winner. Nothing is
  // granted while the tail slot is held.
  always_comb begin
    int idx;
    idx       = 0;
    req_ready = '0;
    dp_load   = 1'b0;
    dp_sel    = '0;
    if (stage_en[STAGE-1]) begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(rr_ptr_q) + k) % N;
        if (!dp_load && elig[idx]) begin
          dp_load        = 1'b1;
          dp_sel         = IDW'(idx);
          req_ready[idx] = 1'b1;
        end
      end
    end
    rr_ptr_d = dp_load ? dp_sel : rr_ptr_q;
  end

  // Slot shift: enabled slots take the slot above, the tail takes the grant.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < STAGE; i++) tag_d[i] = tag_q[i];
    for (int i = 0; i < STAGE - 1; i++) begin
      if (stage_en[i]) begin
        valid_d[i] = valid_q[i+1];
        tag_d[i]   = tag_q[i+1];
      end
    end
    if (stage_en[STAGE-1]) begin
      valid_d[STAGE-1] = dp_load;
      tag_d[STAGE-1]   = dp_sel;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGE; i++) occupancy = occupancy + CW'(valid_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      rr_ptr_q <= IDW'(N - 1);
      for (int i = 0; i < STAGE; i++) tag_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < STAGE; i++) tag_q[i] <= tag_d[i];
    end
  end

endmodule

// File: tb/tb_toomcook_issue_scheduler.sv
module tb_toomcook_issue_scheduler;
  localparam int N = 4, STAGE = 8, MAX_OUT = 3;
`ifdef TOOMCOOK_SCHED_CREDIT_EN
  localparam int T5_GRANTS  = 3;
  localparam int T5_READY12 = 0;
  localparam int T5_READY13 = 4;
`else
  localparam int T5_GRANTS  = 8;
  localparam int T5_READY12 = 4;
  localparam int T5_READY13 = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic         out_ready = 1'b0;
  logic [N-1:0] req_ready;
  logic         dp_load;
  logic [1:0]   dp_sel;
  logic [7:0]   stage_en;
  logic         out_valid;
  logic [1:0]   out_id;
  logic [3:0]   occupancy;

  toomcook_issue_scheduler #(.N(N), .STAGE(STAGE), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .dp_load(dp_load), .dp_sel(dp_sel), .stage_en(stage_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Result monitor: every accepted head result must match the oldest
  // expected ID in the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", int'(out_id), -1);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("out_id", int'(out_id), e);
        $display("result id=%0d expected=%0d", out_id, e);
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_dp_load", dp_load, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_stage_en", stage_en, 8'hFF);
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0; out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      next_cyc();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
    exp_q.delete();
    next_cyc();
    @(negedge clk);
    chk("drain_idle_valid", out_valid, 0);
    chk("drain_idle_occ", occupancy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1: single request latency
    do_reset();
    req_valid = 4'b0001; out_ready = 1'b1;
    @(negedge clk);
    chk("t1_req_ready", req_ready, 1);
    chk("t1_dp_sel", dp_sel, 0);
    chk("t1_dp_load", dp_load, 1);
    exp_q.push_back(0);
    $display("t1 grant id=%0d", dp_sel);
    next_cyc();
    req_valid = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 7) chk("t1_out_valid_c7", out_valid, 0);
      if (c == 8) chk("t1_out_valid_c8", out_valid, 1);
      if (c == 8) chk("t1_occ_c8", occupancy, 1);
      if (c == 9) chk("t1_occ_c9", occupancy, 0);
      next_cyc();
    end
    drain();

    // 2: all requesting, full throughput
    do_reset();
    req_valid = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("t2_dp_load", dp_load, 1);
      chk("t2_req_ready", req_ready, 1 << (c % 4));
      exp_q.push_back(c % 4);
      $display("t2 cycle=%0d grant=%b", c, req_ready);
      next_cyc();
    end
    drain();

    // 3: fill while the consumer stalls, then stream
    do_reset();
    req_valid = 4'hF; out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c < 8) begin
        chk("t3_fill_ready", req_ready, 1 << (c % 4));
        exp_q.push_back(c % 4);
      end else begin
        chk("t3_full_ready", req_ready, 0);
        chk("t3_full_stage_en", stage_en, 0);
        chk("t3_full_occ", occupancy, 8);
      end
      $display("t3 cycle=%0d grant=%b occ=%0d", c, req_ready, occupancy);
      next_cyc();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t3_stream_occ", occupancy, 8);
      chk("t3_stream_ready", req_ready, 1 << c);
      chk("t3_stream_stage_en", stage_en, 8'hFF);
      exp_q.push_back(c);
      $display("t3 stream cycle=%0d grant=%b occ=%0d", c, req_ready, occupancy);
      next_cyc();
    end
    drain();

    // 4: bubble compaction behind a stalled head
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 13; c++) begin
      req_valid = (c == 0) ? 4'b0001 : (c == 3) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (c == 0) begin chk("t4_grant0", req_ready, 1); exp_q.push_back(0); end
      if (c == 3) begin chk("t4_grant3", req_ready, 2); exp_q.push_back(1); end
      if (c == 12) begin
        chk("t4_stage_en", stage_en, 8'hFC);
        chk("t4_occ", occupancy, 2);
        chk("t4_out_valid", out_valid, 1);
        chk("t4_out_id", out_id, 0);
        $display("t4 settled stage_en=%b occ=%0d", stage_en, occupancy);
      end
      next_cyc();
    end
    drain();

    // 5: single requester against the outstanding limit
    do_reset();
    req_valid = 4'b0100; out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c < T5_GRANTS) begin
        chk("t5_grant", req_ready, 4);
        exp_q.push_back(2);
      end else begin
        chk("t5_blocked", req_ready, 0);
      end
      $display("t5 cycle=%0d grant=%b", c, req_ready);
      next_cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_ready_on_release", req_ready, T5_READY12);
    if (T5_READY12 != 0) exp_q.push_back(2);
    $display("t5 release cycle grant=%b", req_ready);
    next_cyc();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t5_ready_after_release", req_ready, T5_READY13);
    if (T5_READY13 != 0) exp_q.push_back(2);
    $display("t5 after release grant=%b", req_ready);
    next_cyc();
    drain();

    // 6: reset in the middle of a stream
    do_reset();
    req_valid = 4'hF; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t6_grant", req_ready, 1 << (c % 4));
      next_cyc();
    end
    req_valid = '0;
    for (int c = 5; c < 10; c++) begin
      @(negedge clk);
      if (c == 9) begin
        chk("t6_occ_before_rst", occupancy, 5);
        chk("t6_valid_before_rst", out_valid, 1);
      end
      next_cyc();
    end
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_occ", occupancy, 0);
    $display("t6 async reset occ=%0d out_valid=%0d", occupancy, out_valid);
    next_cyc();
    rst = 1'b0;
    req_valid = 4'hF;
    @(negedge clk);
    chk("t6_first_grant", req_ready, 1);
    chk("t6_first_sel", dp_sel, 0);
    exp_q.push_back(0);
    $display("t6 first grant=%b", req_ready);
    next_cyc();
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
